// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg -- shared types for the EX/MEM pipeline stage.
//   DATA_W_DEF / RD_W_DEF : default datapath and register-index widths.
//   skid_state_t          : occupancy of the two-entry skid buffer.
//   ex_mem_entry_t        : one buffered execute result with its control
//                           bits and the branch decision taken at capture.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [DATA_W_DEF-1:0] pc_target;
    logic [RD_W_DEF-1:0]   rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  taken;
  } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_if.sv
// ex_mem_if -- bundle of the EX/MEM stage handshake and payload signals.
//   slave  : the stage itself (accepts execute entries, offers memory entries).
//   master : the surrounding pipeline (or a bench) driving the stage.
// Execute side : in_valid/in_ready, alu_result, zero_flag, rd_addr, control
//                bits, store_data, pc_target, flush.
// Memory side  : out_valid/out_ready and the out_* payload.
// Counters     : perf_accepted, perf_stalls.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic [RD_W-1:0]   rd_addr;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch_eq;
  logic              branch_ne;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] pc_target;
  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [DATA_W-1:0] out_pc_target;
  logic [RD_W-1:0]   out_rd_addr;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch_taken;

  logic [31:0]       perf_accepted;
  logic [31:0]       perf_stalls;

  modport slave (
    input  in_valid, alu_result, zero_flag, rd_addr, reg_write, mem_read,
           mem_write, branch_eq, branch_ne, store_data, pc_target, flush,
           out_ready,
    output in_ready, out_valid, out_alu_result, out_store_data, out_pc_target,
           out_rd_addr, out_reg_write, out_mem_read, out_mem_write,
           out_branch_taken, perf_accepted, perf_stalls
  );

  modport master (
    output in_valid, alu_result, zero_flag, rd_addr, reg_write, mem_read,
           mem_write, branch_eq, branch_ne, store_data, pc_target, flush,
           out_ready,
    input  in_ready, out_valid, out_alu_result, out_store_data, out_pc_target,
           out_rd_addr, out_reg_write, out_mem_read, out_mem_write,
           out_branch_taken, perf_accepted, perf_stalls
  );

endinterface

// File: rtl/ex_mem_skid.sv
// ex_mem_skid -- two-entry skid buffer, generic over the entry type.
//   clk, rst          : clock, synchronous active-high reset.
//   flush             : drop everything held; same-cycle input is lost.
//   in_valid/in_ready : upstream handshake (in_ready is a register).
//   in_data           : entry captured on an input transfer.
//   out_valid/out_ready, out_data : downstream handshake, oldest entry.
// head_reg always holds the oldest entry so the outputs come straight from
// a register; tail_reg is the skid slot used only in state TWO.
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter type entry_t = ex_mem_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data
);

  skid_state_t state_reg, state_next;
  entry_t      head_reg, head_next;
  entry_t      tail_reg, tail_next;
  logic        in_ready_reg;
  logic        push;
  logic        pop;

  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;
  assign out_data  = head_reg;
  assign push      = in_valid & in_ready_reg;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_next  = in_data;
            state_next = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_next = in_data;
          end else if (push) begin
            tail_next  = in_data;
            state_next = TWO;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (pop) begin
            head_next  = tail_reg;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      head_reg     <= '0;
      tail_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      // Registered ready: look at where the buffer is going, not where it is.
      in_ready_reg <= (state_next != TWO);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX/MEM pipeline register built on a two-entry skid buffer.
//   clk, rst : clock, synchronous active-high reset (wins over everything).
//   bus      : ex_mem_if slave port carrying both handshakes, payload,
//              flush and the performance counters.
// The branch decision is resolved at capture and travels with the entry.
// Optional feature macro: EX_MEM_PERF_EN enables perf_accepted (input
// transfers) and perf_stalls (cycles with out_valid and not out_ready);
// without it both counters are tied to zero.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);

  // Same layout as ex_mem_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pc_target;
    logic [RD_W-1:0]   rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              taken;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;
  logic   in_ready;
  logic   out_valid;

  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = bus.alu_result;
    in_entry.store_data = bus.store_data;
    in_entry.pc_target  = bus.pc_target;
    in_entry.rd_addr    = bus.rd_addr;
    in_entry.reg_write  = bus.reg_write;
    in_entry.mem_read   = bus.mem_read;
    in_entry.mem_write  = bus.mem_write;
    in_entry.taken      = (bus.branch_eq & bus.zero_flag) |
                          (bus.branch_ne & ~bus.zero_flag);
  end

  ex_mem_skid #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = out_valid;
  assign bus.out_alu_result   = out_entry.alu_result;
  assign bus.out_store_data   = out_entry.store_data;
  assign bus.out_pc_target    = out_entry.pc_target;
  assign bus.out_rd_addr      = out_entry.rd_addr;
  assign bus.out_reg_write    = out_entry.reg_write;
  assign bus.out_mem_read     = out_entry.mem_read;
  assign bus.out_mem_write    = out_entry.mem_write;
  assign bus.out_branch_taken = out_valid & out_entry.taken;

`ifdef EX_MEM_PERF_EN
  logic [31:0] accepted_reg;
  logic [31:0] stalls_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_reg <= '0;
      stalls_reg   <= '0;
    end else begin
      // An input dropped by flush never entered the buffer, so it is not counted.
      if (bus.in_valid && in_ready && !bus.flush) begin
        accepted_reg <= accepted_reg + 32'd1;
      end
      if (out_valid && !bus.out_ready) begin
        stalls_reg <= stalls_reg + 32'd1;
      end
    end
  end

  assign bus.perf_accepted = accepted_reg;
  assign bus.perf_stalls   = stalls_reg;
`else
  assign bus.perf_accepted = 32'd0;
  assign bus.perf_stalls   = 32'd0;
`endif

endmodule
